// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch unit: state encoding,
// program start addresses and branch-target table contents.
package instr_fetch_pkg;

  localparam int PC_W_DEF = 10;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam logic [PC_W_DEF-1:0] START_ADDR [4] = '{
    10'h000, 10'h080, 10'h200, 10'h3FD
  };

  localparam logic [PC_W_DEF-1:0] LUT_TABLE [32] = '{
    10'h000, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040, 10'h3FE, 10'h100,
    10'h123, 10'h155, 10'h1AA, 10'h200, 10'h234, 10'h28F, 10'h2F0, 10'h300,
    10'h311, 10'h333, 10'h355, 10'h377, 10'h399, 10'h3BB, 10'h3DD, 10'h3FF,
    10'h0AA, 10'h0BB, 10'h0CC, 10'h0DD, 10'h0EE, 10'h0FF, 10'h050, 10'h060
  };

endpackage

// File: rtl/instr_fetch_branch_lut.sv
// Combinational branch-target lookup: instruction index field to target PC.
module branch_lut
  import instr_fetch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int LUT_W = 5
) (
  input  logic [LUT_W-1:0] idx,
  output logic [PC_W-1:0]  target
);

  always_comb begin
    target = PC_W'(LUT_TABLE[idx]);
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: LOAD/RUN/HALT sequencer driving the ROM address,
// with branch-target lookup and a saturating RUN-cycle counter.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int LUT_W = 5,
  parameter int CNT_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [1:0]        ProgSel,
  input  logic              Jump,
  input  logic              BranchEn,
  input  logic              Zero,
  input  logic [LUT_W-1:0]  TargetIdx,
  input  logic              Ack,
  output logic [PC_W-1:0]   ProgCtr,
  output logic              Running,
  output logic              Done,
  output logic [CNT_W-1:0]  CycleCt
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic [PC_W-1:0]   lut_target;
  logic [PC_W-1:0]   start_addr;
  logic              taken;

  branch_lut #(.PC_W(PC_W), .LUT_W(LUT_W)) u_branch_lut (
    .idx    (TargetIdx),
    .target (lut_target)
  );

  assign start_addr = PC_W'(START_ADDR[ProgSel]);
  assign taken      = Jump | (BranchEn & Zero);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOAD: begin
        pc_d    = start_addr;
        cnt_d   = {CNT_W{1'b0}};
        state_d = Start ? LOAD : RUN;
      end
      RUN: begin
        cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        // Start aborts the program and clears the count; Ack beats branches.
        if (Start) begin
          state_d = LOAD;
          cnt_d   = {CNT_W{1'b0}};
        end else if (Ack) begin
          state_d = HALT;
        end else if (taken) begin
          pc_d = lut_target;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      HALT: begin
        state_d = Start ? LOAD : HALT;
      end
      default: begin
        state_d = HALT;
      end
    endcase
    running_d = (state_d == RUN);
    done_d    = (state_d == HALT);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= HALT;
      pc_q      <= {PC_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      running_q <= 1'b0;
      done_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign ProgCtr = pc_q;
  assign Running = running_q;
  assign Done    = done_q;
  assign CycleCt = cnt_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter PC_W, default 10, meaning program-counter width in bits.
REQ-002 The block SHALL have parameter LUT_W, default 5, meaning branch-target LUT index width (32 entries).
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning cycle-counter width.
REQ-004 Port Clk  input  1  is the single clock; all state changes on its rising edge.
REQ-005 Port Reset  input  1  is the reset: synchronous, active-low.
REQ-006 Port Start  input  1  requests program load and restart.
REQ-007 Port ProgSel  input  2  selects one of four program start addresses.
REQ-008 Port Jump  input  1  requests an unconditional branch.
REQ-009 Port BranchEn  input  1  requests a conditional branch, taken when Zero=1.
REQ-010 Port Zero  input  1  is the ALU zero flag for the current instruction.
REQ-011 Port TargetIdx  input  LUT_W  is the branch-target LUT index (instruction field).
REQ-012 Port Ack  input  1  is the decoder's "done w/ program" flag (instruction 9'h1FF).
REQ-013 Port ProgCtr  output  PC_W  is the address presented to the instruction ROM.
REQ-014 Port Running  output  1  is high while in state RUN.
REQ-015 Port Done  output  1  is high while in state HALT.
REQ-016 Port CycleCt  output  CNT_W  is the number of RUN cycles since the last load.

Function
REQ-017 The block SHALL implement a three-state machine: LOAD, RUN, HALT.
REQ-018 In LOAD: ProgCtr <= StartAddr[ProgSel] every cycle; CycleCt <= 0; Start=0 -> RUN next cycle; Start=1 -> stay in LOAD.
REQ-019 In RUN, with taken = Jump | (BranchEn & Zero): taken -> ProgCtr <= Lut[TargetIdx]; else ProgCtr <= ProgCtr+1 mod 2^PC_W (1023 -> 0 wraps, no flag).
REQ-020 In RUN: CycleCt increments by 1 per cycle and saturates at 2^CNT_W-1.
REQ-021 In RUN with Ack=1: next state is HALT and ProgCtr holds; Ack takes priority over Jump and branch on the same cycle.
REQ-022 In RUN with Start=1: next state is LOAD, overriding Ack and branch, which aborts the program.
REQ-023 In HALT: ProgCtr and CycleCt hold; Jump, BranchEn and Ack are ignored; Start=1 -> LOAD; else stay in HALT.
REQ-024 Outputs SHALL be registered: Running = (state==RUN); Done = (state==HALT); no combinational path from inputs to outputs.
REQ-025 Lut[] and StartAddr[] lookups SHALL be combinational with zero latency; ProgCtr updates one cycle after the qualifying inputs.
REQ-026 Jump and BranchEn both high SHALL mean taken, whatever the value of Zero.

Reset
REQ-027 When Reset=0 at a clock edge: state <= HALT, ProgCtr <= 0, CycleCt <= 0, Done=1, Running=0.
REQ-028 Reset SHALL override Start, Ack and branch inputs on the same edge, and mid-program reset SHALL abort the run.
REQ-029 After Reset deasserts, the block SHALL stay in HALT until Start=1.

Structure
REQ-030 Package definitions SHALL hold the PC_W default, the state enum {LOAD, RUN, HALT}, the StartAddr table (4 x PC_W) and the Lut contents (32 x PC_W).
REQ-031 Sub-module branch_lut (combinational: TargetIdx -> target address, constants from definitions) SHALL be instantiated once.
REQ-032 All sequential logic SHALL be in a single clocked process; next-state and next-PC logic SHALL be combinational.

Verification
REQ-033 Reset=0 for 2 cycles, then release -> ProgCtr=0, Done=1, Running=0, CycleCt=0; state remains HALT for 5 idle cycles.
REQ-034 StartAddr[1]=0x080; ProgSel=1, Start high for 3 cycles then low -> ProgCtr=0x080 during LOAD, then 0x081, 0x082 on successive cycles; CycleCt 1, 2.
REQ-035 Lut[3]=0x010 and RUN at ProgCtr 0x085: BranchEn=1, Zero=0, TargetIdx=3 -> 0x086; BranchEn=1, Zero=1 -> 0x010; Jump=1 -> 0x010.
REQ-036 RUN at ProgCtr 0x3FF with no branch -> ProgCtr 0x000 next cycle, Running stays 1.
REQ-037 RUN with Ack=1 and Jump=1 on the same cycle -> HALT, ProgCtr unchanged, Done=1 next cycle; later Jump pulses leave ProgCtr unchanged.
REQ-038 RUN with Start=1 and Ack=1 together -> LOAD, CycleCt=0; Reset=0 mid-RUN -> ProgCtr=0, HALT.
